// File: rtl/dsp_result_drain.sv
// dsp_result_drain: output-side drain for the fixed-point DSP slice.
// A {valid, split} delay line follows the slice's fixed latency so that
// resulta/resultb are captured on the edge they are valid. Each operand is
// shifted, optionally rounded, saturated to OUT_W bits and queued in a small
// FIFO with a ready/valid head. The slice cannot stall. A result that finds
// too few free slots is dropped whole and raises the sticky overflow flag.
// Build option: define DSP_DRAIN_ROUND_EN to add 2^(SHIFT-1) before the shift
// (round-half-up). Without it the shift truncates toward minus infinity.
`timescale 1ns/1ps

module dsp_result_drain #(
    parameter int OUT_W   = 32,
    parameter int SHIFT   = 16,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_split,
    input  logic [63:0]              resulta,
    input  logic [36:0]              resultb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } entry_t;

    // Scale one 72-bit signed operand down to OUT_W bits, clamping on overflow.
    function automatic entry_t shape(input logic signed [71:0] x);
        logic signed [71:0] t;
        logic signed [71:0] max_v;
        logic signed [71:0] min_v;
        entry_t             e;
        max_v = (72'sd1 <<< (OUT_W - 1)) - 72'sd1;
        min_v = -(72'sd1 <<< (OUT_W - 1));
`ifdef DSP_DRAIN_ROUND_EN
        t = x + (72'sd1 <<< (SHIFT - 1));
`else
        t = x;
`endif
        t = t >>> SHIFT;
        if (t > max_v) begin
            e.sat  = 1'b1;
            e.data = max_v[OUT_W-1:0];
        end else if (t < min_v) begin
            e.sat  = 1'b1;
            e.data = min_v[OUT_W-1:0];
        end else begin
            e.sat  = 1'b0;
            e.data = t[OUT_W-1:0];
        end
        return e;
    endfunction

    logic [LATENCY-1:0] dl_valid_q;
    logic [LATENCY-1:0] dl_split_q;
    logic               cap_valid;
    logic               cap_split;

    logic signed [71:0] lo_ext;
    logic signed [71:0] hi_ext;
    entry_t             lo_ent;
    entry_t             hi_ent;

    entry_t             mem_q [DEPTH];
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic [LW-1:0]      free_slots;
    logic [LW-1:0]      need_slots;
    logic [LW-1:0]      push_n;
    logic [LW-1:0]      remain;
    logic               pop;
    logic               accept;
    logic               drop;

    logic               out_valid_q, out_valid_d;
    entry_t             head_q, head_d;
    logic               overflow_q, overflow_d;

    // Bit 36 of resultb carries nothing for this stage.
    logic               unused_resultb_msb;
    assign unused_resultb_msb = resultb[36];

    // Delay line: track {valid, split} of each issue until the slice result is due.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // reads the value from before this edge; blocking here would collapse the line.
        if (reset) begin
            dl_valid_q <= '0;
            dl_split_q <= '0;
        end else begin
            dl_valid_q[0] <= issue_valid;
            dl_split_q[0] <= issue_split;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_split_q[i] <= dl_split_q[i-1];
            end
        end
    end

    assign cap_valid = dl_valid_q[LATENCY-1];
    assign cap_split = dl_split_q[LATENCY-1];

    // Operand selection: one 64-bit value, or two 36-bit halves in split mode.
    always_comb begin
        lo_ext = cap_split ? {{36{resulta[35]}}, resulta[35:0]}
                           : {{8{resulta[63]}}, resulta};
        hi_ext = {{36{resultb[35]}}, resultb[35:0]};
        lo_ent = shape(lo_ext);
        hi_ent = shape(hi_ext);
    end

    // FIFO control: space check after the same-cycle pop, pointers, next head.
    always_comb begin
        // NOTE: every output of this block is assigned on all paths (head_d gets
        // its hold value first) so no latch is inferred.
        pop         = out_valid_q && out_ready;
        free_slots  = LW'(DEPTH) - count_q + LW'(pop);
        need_slots  = cap_split ? LW'(2) : LW'(1);
        accept      = cap_valid && (free_slots >= need_slots);
        drop        = cap_valid && !accept;
        push_n      = accept ? need_slots : '0;
        wptr_d      = wptr_q + AW'(push_n);
        rptr_d      = rptr_q + AW'(pop);
        remain      = count_q - LW'(pop);
        count_d     = remain + push_n;
        out_valid_d = (count_d != '0);
        head_d      = head_q;
        if (remain != '0) begin
            head_d = mem_q[rptr_d];
        end else if (accept) begin
            head_d = lo_ent;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage: lower (or only) operand at wptr, upper at wptr+1.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the cleared pointers and count make old
        // contents unreachable, and leaving it out keeps the array a plain RAM.
        if (accept) begin
            mem_q[wptr_q] <= lo_ent;
            if (cap_split) begin
                mem_q[wptr_q + AW'(1)] <= hi_ent;
            end
        end
    end

    // Pointer, occupancy, registered head and sticky overflow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q.data;
    assign out_sat   = head_q.sat;
    assign overflow  = overflow_q;
    assign level     = count_q;

endmodule

// File: tb/tb_dsp_result_drain.sv
// Bench for dsp_result_drain (OUT_W=32, SHIFT=16, DEPTH=8, LATENCY=4).
// Results are scheduled to appear on resulta/resultb LATENCY edges after
// their issue; expected FIFO entries go into a scoreboard queue at the capture
// edge and are compared against out_data/out_sat when the bench pops them.
`timescale 1ns/1ps

module tb_dsp_result_drain;

    localparam int OUT_W   = 32;
    localparam int SHIFT   = 16;
    localparam int DEPTH   = 8;
    localparam int LATENCY = 4;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic              issue_split;
    logic [63:0]       resulta;
    logic [36:0]       resultb;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              overflow;
    logic              clr_ovf;
    logic [3:0]        level;

    dsp_result_drain #(
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_split (issue_split),
        .resulta     (resulta),
        .resultb     (resultb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        split;
        logic [63:0] a;
        logic [36:0] b;
        logic [31:0] d_lo;
        logic        s_lo;
        logic [31:0] d_hi;
        logic        s_hi;
    } pend_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;

    pend_t pend_q[$];
    exp_t  sb_q[$];
    pend_t nxt;
    int    cyc;
    int    checks;
    int    errors;
    logic  ovf_exp;

`ifdef DSP_DRAIN_ROUND_EN
    localparam logic [31:0] ROUND_EXP = 32'h0001_8001;
`else
    localparam logic [31:0] ROUND_EXP = 32'h0001_8000;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: extend, optional half-LSB add, floor shift, clamp.
    function automatic exp_t model(input logic signed [71:0] x);
        exp_t e;
        logic signed [71:0] t;
        t = x;
`ifdef DSP_DRAIN_ROUND_EN
        t = t + 72'sd32768;
`endif
        t = t >>> SHIFT;
        if (t > 72'sd2147483647) begin
            e.d = 32'h7FFF_FFFF; e.s = 1'b1;
        end else if (t < -72'sd2147483648) begin
            e.d = 32'h8000_0000; e.s = 1'b1;
        end else begin
            e.d = t[31:0]; e.s = 1'b0;
        end
        return e;
    endfunction

    // Directed non-split result with hand-derived expectation.
    task automatic set_ns(input logic [63:0] a, input logic [31:0] d, input logic s);
        nxt.split = 1'b0;
        nxt.a     = a;
        nxt.b     = 37'({$urandom, $urandom});
        nxt.d_lo  = d;
        nxt.s_lo  = s;
        nxt.d_hi  = '0;
        nxt.s_hi  = 1'b0;
    endtask

    // Random result (split or not) with model-derived expectation.
    task automatic set_rand(input logic split);
        logic [63:0] r;
        exp_t        lo;
        exp_t        hi;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            1: r = {{24{r[39]}}, r[39:0]};
            2: r = {{16{r[47]}}, r[47:0]};
            default: ;
        endcase
        nxt.split = split;
        nxt.a     = r;
        nxt.b     = 37'({$urandom, $urandom});
        if (split) begin
            lo = model({{36{r[35]}}, r[35:0]});
            hi = model({{36{nxt.b[35]}}, nxt.b[35:0]});
        end else begin
            lo = model({{8{r[63]}}, r});
            hi = '{d: 32'h0, s: 1'b0};
        end
        nxt.d_lo = lo.d;
        nxt.s_lo = lo.s;
        nxt.d_hi = hi.d;
        nxt.s_hi = hi.s;
    endtask

    // One clock: drive inputs, update the scoreboard, then check after the edge.
    task automatic step(input logic iv, input logic rdy, input logic clr, input logic rst);
        pend_t p;
        logic  cap;
        logic  drop;
        int    free_n;
        int    need;
        issue_valid = iv;
        issue_split = iv ? nxt.split : 1'($urandom);
        out_ready   = rdy;
        clr_ovf     = clr;
        reset       = rst;
        resulta     = {$urandom, $urandom};
        resultb     = 37'({$urandom, $urandom});
        cap         = 1'b0;
        drop        = 1'b0;
        p           = nxt;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p       = pend_q.pop_front();
            cap     = 1'b1;
            resulta = p.a;
            resultb = p.b;
        end
        if (rdy && sb_q.size() > 0) begin
            check("head_data", 64'(out_data), 64'(sb_q[0].d));
            check("head_sat", 64'(out_sat), 64'(sb_q[0].s));
            sb_q.delete(0);
        end
        if (cap && !rst) begin
            need   = p.split ? 2 : 1;
            free_n = DEPTH - sb_q.size();
            if (free_n >= need) begin
                sb_q.push_back('{d: p.d_lo, s: p.s_lo});
                if (p.split) sb_q.push_back('{d: p.d_hi, s: p.s_hi});
            end else begin
                drop = 1'b1;
            end
        end
        if (iv) begin
            nxt.due = cyc + LATENCY;
            pend_q.push_back(nxt);
        end
        if (rst) begin
            pend_q.delete();
            sb_q.delete();
            ovf_exp = 1'b0;
        end else if (drop) begin
            ovf_exp = 1'b1;
        end else if (clr) begin
            ovf_exp = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        check("level", 64'(level), 64'(sb_q.size()));
        check("overflow", 64'(overflow), 64'(ovf_exp));
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; ovf_exp = 1'b0;
        reset = 1'b1; issue_valid = 1'b0; issue_split = 1'b0;
        out_ready = 1'b0; clr_ovf = 1'b0; resulta = '0; resultb = '0;
        set_ns(64'h0, 32'h0, 1'b0);

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_out_sat", 64'(out_sat), 64'h0);

        // Rounding and latency: out_valid must rise exactly after E(LATENCY).
        set_ns(64'h0000_0001_8000_8000, ROUND_EXP, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        check("latency_low_after_E3", 64'(out_valid), 64'h0);
        idle(1, 1'b1);
        check("latency_high_after_E4", 64'(out_valid), 64'h1);
        check("round_data", 64'(out_data), 64'(ROUND_EXP));
        idle(3, 1'b1);

        // Saturation both directions, back to back.
        set_ns(64'h0000_8000_0000_0000, 32'h7FFF_FFFF, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        set_ns(64'hFFFF_0000_0000_0000, 32'h8000_0000, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(7, 1'b1);

        // Split: two entries land on one edge, lower first.
        nxt.split = 1'b1;
        nxt.a     = {28'hABC_DEF1, 36'h0_0003_0000};
        nxt.b     = {1'b1, 36'hF_FFFE_0000};
        nxt.d_lo  = 32'h0000_0003; nxt.s_lo = 1'b0;
        nxt.d_hi  = 32'hFFFF_FFFE; nxt.s_hi = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("split_level_before", 64'(level), 64'h0);
        idle(1, 1'b0);
        check("split_level_after", 64'(level), 64'h2);
        idle(3, 1'b1);

        // Full FIFO: 9 non-split arrivals, the 9th dropped.
        for (int i = 0; i < 9; i++) begin
            set_rand(1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(4, 1'b0);
        check("full_level", 64'(level), 64'h8);
        check("full_overflow", 64'(overflow), 64'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_overflow", 64'(overflow), 64'h0);

        // Level 7 with a split arrival: whole pair dropped.
        idle(1, 1'b1);
        set_rand(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("split_drop_level", 64'(level), 64'h7);
        check("split_drop_overflow", 64'(overflow), 64'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Refill to 8, then a capture coinciding with a pop at full.
        set_rand(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        set_rand(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        check("pop_at_full_level", 64'(level), 64'h8);
        check("pop_at_full_overflow", 64'(overflow), 64'h0);
        idle(10, 1'b1);

        // Random mix of splits, stalls and clears.
        for (int i = 0; i < 60; i++) begin
            set_rand(1'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0), 1'b0);
        end
        idle(LATENCY + 2 * DEPTH, 1'b1);

        // Reset mid-flight: three issues, reset on the following edge.
        for (int i = 0; i < 3; i++) begin
            set_rand(1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(8, 1'b1);
        check("midreset_level", 64'(level), 64'h0);
        check("midreset_overflow", 64'(overflow), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
